// File: rtl/game_time_display.sv
// Game time display: converts the 10-bit game-clock count to BCD with a
// sequential double-dabble engine, drives four active-low 7-segment digits
// and reports when the converted time has reached TIME_LIMIT.
//
// Handshake: there is no valid/ready pair. A conversion starts when the FSM
// is idle and count_in differs from the last converted value. busy stays high
// until the DONE edge, on which bcd_out, HEX0..HEX3, time_up and
// time_up_pulse all update together and busy falls. Changes to count_in while
// busy are not queued; whatever count_in holds once idle is converted next.
module game_time_display #(
   parameter logic [9:0] TIME_LIMIT    = 10'd600,
   parameter bit         BLANK_LEADING = 1'b1
) (
   input  logic        CLOCK10M,
   input  logic        RST_N,
   input  logic [9:0]  count_in,
   output logic [15:0] bcd_out,
   output logic [6:0]  HEX0,
   output logic [6:0]  HEX1,
   output logic [6:0]  HEX2,
   output logic [6:0]  HEX3,
   output logic        busy,
   output logic        time_up,
   output logic        time_up_pulse,
   output logic [1:0]  fsm_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK    = 7'b1111111;
   localparam logic [6:0] SEG_ZERO     = 7'b1000000;
   localparam logic [6:0] LEAD_RST_SEG = BLANK_LEADING ? SEG_BLANK : SEG_ZERO;

   state_t      state;
   state_t      state_next;
   logic [9:0]  last_val;
   logic [9:0]  captured;
   logic [9:0]  bin_sr;
   logic [15:0] acc;
   logic [3:0]  iter;
   logic [15:0] acc_adj;
   logic [25:0] shifted;
   logic        start;
   logic        tu_next;
   logic        blank3;
   logic        blank2;
   logic        blank1;
   logic [6:0]  hex0_next;
   logic [6:0]  hex1_next;
   logic [6:0]  hex2_next;
   logic [6:0]  hex3_next;

   // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit.
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Double-dabble correction: every nibble >= 5 gets 3 added before the shift.
   function automatic logic [15:0] add3_nibbles(input logic [15:0] a);
      logic [15:0] r;
      for (int n = 0; n < 4; n++) begin
         r[n*4 +: 4] = (a[n*4 +: 4] >= 4'd5) ? a[n*4 +: 4] + 4'd3 : a[n*4 +: 4];
      end
      return r;
   endfunction

   assign fsm_state = state;
   assign start     = (count_in != last_val);
   assign tu_next   = (captured >= TIME_LIMIT);

   // One double-dabble step: correct nibbles, then shift {acc, bin} left.
   always_comb begin
      acc_adj = add3_nibbles(acc);
      shifted = {acc_adj, bin_sr} << 1;
   end

   // Digit decode of the finished accumulator, with optional leading blanking.
   always_comb begin
      blank3    = BLANK_LEADING && (acc[15:12] == 4'd0);
      blank2    = blank3 && (acc[11:8] == 4'd0);
      blank1    = blank2 && (acc[7:4] == 4'd0);
      hex0_next = seg_decode(acc[3:0]);
      hex1_next = blank1 ? SEG_BLANK : seg_decode(acc[7:4]);
      hex2_next = blank2 ? SEG_BLANK : seg_decode(acc[11:8]);
      hex3_next = blank3 ? SEG_BLANK : seg_decode(acc[15:12]);
   end

   // FSM state register.
   always_ff @(posedge CLOCK10M or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_next;
   end

   // FSM next state: ten shift steps, then one DONE edge to publish results.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = SHIFT;
         SHIFT:   if (iter == 4'd9) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Conversion datapath and registered outputs.
   always_ff @(posedge CLOCK10M or negedge RST_N) begin
      if (!RST_N) begin
         last_val      <= 10'd0;
         captured      <= 10'd0;
         bin_sr        <= 10'd0;
         acc           <= 16'd0;
         iter          <= 4'd0;
         bcd_out       <= 16'd0;
         HEX0          <= SEG_ZERO;
         HEX1          <= LEAD_RST_SEG;
         HEX2          <= LEAD_RST_SEG;
         HEX3          <= LEAD_RST_SEG;
         busy          <= 1'b0;
         time_up       <= 1'b0;
         time_up_pulse <= 1'b0;
      end else begin
         time_up_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  bin_sr   <= count_in;
                  captured <= count_in;
                  acc      <= 16'd0;
                  iter     <= 4'd0;
                  busy     <= 1'b1;
               end
            end
            SHIFT: begin
               acc    <= shifted[25:10];
               bin_sr <= shifted[9:0];
               iter   <= iter + 4'd1;
            end
            DONE: begin
               bcd_out       <= acc;
               last_val      <= captured;
               HEX0          <= hex0_next;
               HEX1          <= hex1_next;
               HEX2          <= hex2_next;
               HEX3          <= hex3_next;
               time_up       <= tu_next;
               time_up_pulse <= tu_next & ~time_up;
               busy          <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_game_time_display.sv
// Bench for game_time_display: drives count values, predicts each published
// result from decimal arithmetic, and checks results as busy falls.
module tb_game_time_display;

   localparam int W = 46;  // {bcd16, hex3, hex2, hex1, hex0, time_up, pulse}

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  count_in = 10'd0;
   logic [15:0] bcd_out;
   logic [6:0]  hex0, hex1, hex2, hex3;
   logic        busy, time_up, time_up_pulse;
   logic [1:0]  fsm_state;

   int vectors = 0;
   int miscompares = 0;
   logic [W-1:0] exp_q[$];
   logic [9:0]   model_last = 10'd0;
   logic         model_tu = 1'b0;
   logic         prev_busy = 1'b0;
   logic [W-1:0] exp_v;
   logic [W-1:0] act_v;

   // Clock and DUT.
   always #50 clk = ~clk;

   game_time_display #(.TIME_LIMIT(10'd600), .BLANK_LEADING(1'b1)) dut (
      .CLOCK10M(clk), .RST_N(rst_n), .count_in(count_in), .bcd_out(bcd_out),
      .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .busy(busy),
      .time_up(time_up), .time_up_pulse(time_up_pulse), .fsm_state(fsm_state)
   );

   // Reference segment table.
   function automatic logic [6:0] ref_seg(input int d);
      case (d)
         0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
         3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
         6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
         9: return 7'b0010000;  default: return 7'b1111111;
      endcase
   endfunction

   // Reference result for value v given the previous time_up.
   function automatic logic [W-1:0] ref_result(input int v, input logic prev_tu);
      int th, hu, te, on;
      logic [6:0] h3, h2, h1, h0;
      logic tu;
      th = v / 1000; hu = (v / 100) % 10; te = (v / 10) % 10; on = v % 10;
      h0 = ref_seg(on);
      h1 = (v < 10)   ? 7'b1111111 : ref_seg(te);
      h2 = (v < 100)  ? 7'b1111111 : ref_seg(hu);
      h3 = (v < 1000) ? 7'b1111111 : ref_seg(th);
      tu = (v >= 600);
      return {th[3:0], hu[3:0], te[3:0], on[3:0], h3, h2, h1, h0, tu, tu & ~prev_tu};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: pops one expected result on every busy falling edge; pulse must be 0 otherwise.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_busy = 1'b0;
      end else begin
         if (prev_busy && !busy) begin
            act_v = {bcd_out, hex3, hex2, hex1, hex0, time_up, time_up_pulse};
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL result: unexpected completion got %h, expected none", act_v);
            end else begin
               exp_v = exp_q.pop_front();
               if (act_v !== exp_v) begin
                  miscompares++;
                  $display("FAIL result: got %h, expected %h at %0t", act_v, exp_v, $time);
               end
            end
         end else begin
            check("pulse_idle", {63'd0, time_up_pulse}, 64'd0);
         end
         prev_busy = busy;
      end
   end

   // Queue an expected result if v will trigger a conversion.
   task automatic push_expect(input logic [9:0] v);
      if (v != model_last) begin
         exp_q.push_back(ref_result(int'(v), model_tu));
         model_tu   = (v >= 10'd600);
         model_last = v;
      end
   endtask

   // Wait (bounded) until busy equals lvl at a negedge; cnt counts cycles waited.
   task automatic wait_busy(input logic lvl, inout int cnt);
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         @(negedge clk);
         cnt++;
         if (busy === lvl) return;
      end
      vectors++;
      miscompares++;
      $display("FAIL wait_busy: timeout waiting for busy=%0b", lvl);
   endtask

   // Apply one value and wait for its conversion (or check that none starts).
   task automatic apply(input logic [9:0] v);
      int cnt;
      logic conv;
      @(negedge clk);
      count_in = v;
      conv = (v != model_last);
      push_expect(v);
      if (conv) begin
         cnt = 0;
         wait_busy(1'b0, cnt);
         check("latency", 64'(cnt), 64'd12);
      end else begin
         repeat (3) @(negedge clk);
         check("busy_no_change", {63'd0, busy}, 64'd0);
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_bcd", 64'(bcd_out), 64'd0);
      check("rst_hex0", 64'(hex0), 64'b1000000);
      check("rst_hex1", 64'(hex1), 64'b1111111);
      check("rst_hex2", 64'(hex2), 64'b1111111);
      check("rst_hex3", 64'(hex3), 64'b1111111);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_time_up", {63'd0, time_up}, 64'd0);
      check("rst_pulse", {63'd0, time_up_pulse}, 64'd0);
   endtask

   initial begin
      int cnt;
      logic [9:0] v;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      rst_n = 1'b1;

      // Idle with count 0: nothing should start.
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         check("idle_busy", {63'd0, busy}, 64'd0);
      end
      check("idle_bcd", 64'(bcd_out), 64'd0);

      // Directed values, time limit crossing and a repeated value.
      apply(10'd537);
      apply(10'd1023);
      apply(10'd7);
      apply(10'd599);
      apply(10'd600);
      apply(10'd0);
      apply(10'd0);
      apply(10'd100);

      // Value change while busy: reconverted after the first completes.
      @(negedge clk);
      count_in = 10'd101;
      push_expect(10'd101);
      cnt = 0;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         cnt++;
      end
      count_in = 10'd102;
      push_expect(10'd102);
      wait_busy(1'b0, cnt);
      check("first_done", 64'(cnt), 64'd12);
      wait_busy(1'b1, cnt);
      wait_busy(1'b0, cnt);
      check("second_done", 64'(cnt), 64'd24);

      // Reset in the middle of a conversion.
      apply(10'd1000);
      @(negedge clk);
      count_in = 10'd900;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      exp_q.delete();
      model_last = 10'd0;
      model_tu = 1'b0;
      #1;
      check_reset_outputs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      push_expect(10'd900);
      cnt = 0;
      wait_busy(1'b0, cnt);
      check("post_reset_latency", 64'(cnt), 64'd12);

      // Randomized values, with occasional repeats.
      for (int i = 0; i < 40; i++) begin
         v = 10'($urandom_range(0, 1023));
         if ($urandom_range(0, 7) == 0) v = model_last;
         apply(v);
      end

      repeat (5) @(negedge clk);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
